// File: rtl/frac_mul_pipe.sv
`timescale 1ns/1ps
// frac_mul_pipe: pipelined unsigned fractional multiplier (A/2^N * B/2^N).
// A valid/ready stage chain carries the product and a window-gate flag.
// When a gated beat reaches the output, the last non-gated product is
// replayed in place of the freshly computed one.
module frac_mul_pipe #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] mul_in1,
    input  logic [N-1:0] mul_in2,
    input  logic [N-1:0] counter,
    input  logic [N-1:0] t,
    input  logic         round_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] mul_out,
    output logic         out_gated
);

    logic             advance;
    logic             accept;
    logic [2*N-1:0]   prod;
    logic [2*N-1:0]   prod_rnd;
    logic [N:0]       win_limit;
    logic             win_open;
    logic [N-1:0]     res_new;
    logic             gated_new;
    logic [N-1:0]     last_prod;

    // Index STAGES-1 is the output register; lower indices are the
    // internal pipeline stages (none when STAGES is 1).
    logic             valid_q [STAGES];
    logic [N-1:0]     res_q   [STAGES];
    logic             gated_q [STAGES];
    logic             valid_d [STAGES];
    logic [N-1:0]     res_d   [STAGES];
    logic             gated_d [STAGES];

    // The whole chain moves together whenever the output slot is free or drained.
    always_comb begin
        advance  = out_ready | ~valid_q[STAGES-1];
        in_ready = advance;
        accept   = in_valid & advance;
    end

    // Stage-1 arithmetic and window decision, computed from the incoming beat.
    always_comb begin
        prod     = {{N{1'b0}}, mul_in1} * {{N{1'b0}}, mul_in2};
        prod_rnd = prod;
        if (round_mode) begin
            prod_rnd = prod + ((2*N)'(1) << (N-1));
        end
        res_new   = N'(prod_rnd >> N);
        win_limit = (N+1)'(1) << t;
        win_open  = ({1'b0, t} >= (N+1)'(N)) | ({1'b0, counter} <= win_limit);
        gated_new = ~win_open;
    end

    // Feed of each stage: stage 0 takes the new beat, later stages take their predecessor.
    always_comb begin
        valid_d[0] = accept;
        res_d[0]   = res_new;
        gated_d[0] = gated_new;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            res_d[k]   = res_q[k-1];
            gated_d[k] = gated_q[k-1];
        end
    end

    // Shift the chain on advance; the output stage substitutes last_prod for gated beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                res_q[k]   <= '0;
                gated_q[k] <= 1'b0;
            end
            last_prod <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES-1; k++) begin
                valid_q[k] <= valid_d[k];
                res_q[k]   <= res_d[k];
                gated_q[k] <= gated_d[k];
            end
            valid_q[STAGES-1] <= valid_d[STAGES-1];
            if (valid_d[STAGES-1]) begin
                if (gated_d[STAGES-1]) begin
                    res_q[STAGES-1]   <= last_prod;
                    gated_q[STAGES-1] <= 1'b1;
                end else begin
                    res_q[STAGES-1]   <= res_d[STAGES-1];
                    gated_q[STAGES-1] <= 1'b0;
                    last_prod         <= res_d[STAGES-1];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign mul_out   = res_q[STAGES-1];
    assign out_gated = gated_q[STAGES-1];

endmodule
